// File: rtl/aes_round_sequencer.sv
`timescale 1ns/1ps
// Iterative AES round sequencer: latches block/key, then steps the datapath through LOAD and rounds 1..NR.
// Latency: accept to out_valid is 2*NR+1 edges with a single-cycle datapath ack (one cycle more per ack delay).
// Backpressure: in_ready is low while busy, faulted, or while a finished ciphertext waits for out_ready.

module aes_round_sequencer #(
    parameter int KEY_W   = 128,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic [127:0]     dp_block,
    output logic [KEY_W-1:0] dp_key,
    output logic             dp_load,
    output logic             dp_round_go,
    output logic [3:0]       dp_round_num,
    output logic             dp_final,
    input  logic             dp_round_done,
    input  logic [127:0]     dp_state,
    output logic             busy,
    output logic             err,
    output logic             LED
);

    localparam int         NR       = KEY_W / 32 + 6;
    localparam logic [3:0] NR_L     = 4'(NR);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_WAIT, S_ERR} state_t;

    state_t     state, state_nxt;
    logic [3:0] round;
    logic [7:0] tmo;
    logic       accept;
    logic       last_round;
    logic       complete;

    // rst is folded in so in_ready reads 0 while reset is held, not just after it.
    assign in_ready     = !rst && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign last_round   = (round == NR_L);
    assign complete     = (state == S_WAIT) && dp_round_done && last_round;
    assign err          = (state == S_ERR);
    assign LED          = out_valid;
    assign dp_round_num = round;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        dp_load     = 1'b0;
        dp_round_go = 1'b0;
        dp_final    = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                dp_load   = 1'b1;
                busy      = 1'b1;
                state_nxt = S_ROUND;
            end
            S_ROUND: begin
                dp_round_go = 1'b1;
                dp_final    = last_round;
                busy        = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (dp_round_done)        state_nxt = last_round ? S_IDLE : S_ROUND;
                else if (tmo == TMO_LAST) state_nxt = S_ERR;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_block  <= '0;
            dp_key    <= '0;
            out_block <= '0;
            out_valid <= 1'b0;
            round     <= '0;
            tmo       <= '0;
        end else begin
            if (accept) begin
                dp_block <= in_block;
                dp_key   <= in_key;
            end
            case (state)
                S_IDLE:  if (accept) round <= '0;
                S_LOAD:  round <= 4'd1;
                S_ROUND: tmo <= '0;
                S_WAIT: begin
                    if (dp_round_done) begin
                        if (last_round) round <= '0;
                        else            round <= round + 4'd1;
                    end else if (tmo != 8'hff) begin
                        tmo <= tmo + 8'd1;
                    end
                end
                default: ;
            endcase
            // A completion wins over a drain in the same cycle so the new result is never lost.
            if (complete) begin
                out_block <= dp_state;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
